// File: rtl/alarm_ctrl_unit_pkg.sv
// Shared widths, state codes and default timing for the alarm sequencer.
// Optional weekday masking is enabled with `define ALARM_CTRL_WEEKDAY_EN.
package alarm_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZE  = 2'd2;

  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int SNOOZE_S_DEF       = 300;
  localparam int MAX_SNOOZE_DEF     = 3;
  localparam int CNT_W_DEF          = 9;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } tod_t;
endpackage

// File: rtl/alarm_ctrl_unit_if.sv
// Time, alarm-setting, button and piezo-control signals of the alarm sequencer.
// Weekday signals exist only when ALARM_CTRL_WEEKDAY_EN is defined.
interface alarm_ctrl_unit_if;
  import alarm_pkg::*;

  logic              SEC_TICK;
  logic [HOUR_W-1:0] CUR_HOUR;
  logic [MIN_W-1:0]  CUR_MIN;
  logic [SEC_W-1:0]  CUR_SEC;
  logic [HOUR_W-1:0] ALM_HOUR;
  logic [MIN_W-1:0]  ALM_MIN;
  logic              ALM_ARMED;
  logic              BTN_STOP;
  logic              BTN_SNOOZE;
  logic              ALARM_ENABLE;
  logic              ALARM_DOING;
  logic [1:0]        ALM_STATE;
  logic [1:0]        SNOOZE_LEFT;
`ifdef ALARM_CTRL_WEEKDAY_EN
  logic [2:0]        CUR_DOW;
  logic [6:0]        ALM_DOW_MASK;
`endif

  modport master (
`ifdef ALARM_CTRL_WEEKDAY_EN
    output CUR_DOW, ALM_DOW_MASK,
`endif
    output SEC_TICK, CUR_HOUR, CUR_MIN, CUR_SEC, ALM_HOUR, ALM_MIN,
    output ALM_ARMED, BTN_STOP, BTN_SNOOZE,
    input  ALARM_ENABLE, ALARM_DOING, ALM_STATE, SNOOZE_LEFT
  );

  modport slave (
`ifdef ALARM_CTRL_WEEKDAY_EN
    input  CUR_DOW, ALM_DOW_MASK,
`endif
    input  SEC_TICK, CUR_HOUR, CUR_MIN, CUR_SEC, ALM_HOUR, ALM_MIN,
    input  ALM_ARMED, BTN_STOP, BTN_SNOOZE,
    output ALARM_ENABLE, ALARM_DOING, ALM_STATE, SNOOZE_LEFT
  );
endinterface

// File: rtl/alarm_ctrl_unit_match.sv
// Alarm time comparator: single-cycle TRIGGER at hh:mm:00 of the alarm minute,
// at most once per matching minute (fired flag). Weekday mask under ALARM_CTRL_WEEKDAY_EN.
module alarm_match
  import alarm_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SEC_TICK,
  input  tod_t              cur,
  input  logic [HOUR_W-1:0] ALM_HOUR,
  input  logic [MIN_W-1:0]  ALM_MIN,
  input  logic              ALM_ARMED,
`ifdef ALARM_CTRL_WEEKDAY_EN
  input  logic [2:0]        CUR_DOW,
  input  logic [6:0]        ALM_DOW_MASK,
`endif
  output logic              TRIGGER
);
  logic fired;
  logic same_min;
  logic dow_ok;

  assign same_min = (cur.hour == ALM_HOUR) && (cur.min == ALM_MIN);

`ifdef ALARM_CTRL_WEEKDAY_EN
  // Pad the mask so day code 7 lands on a constant zero.
  logic [7:0] mask_ext;
  assign mask_ext = {1'b0, ALM_DOW_MASK};
  assign dow_ok   = mask_ext[CUR_DOW];
`else
  assign dow_ok   = 1'b1;
`endif

  // Combinational so the FSM can move on the very edge that samples the tick.
  assign TRIGGER = SEC_TICK & ALM_ARMED & same_min & (cur.sec == '0) & ~fired & dow_ok;

  always_ff @(posedge CLK) begin
    if (RESET)          fired <= 1'b0;
    else if (!same_min) fired <= 1'b0;
    else if (TRIGGER)   fired <= 1'b1;
  end
endmodule

// File: rtl/alarm_ctrl_unit.sv
// Alarm sequencer IDLE/RINGING/SNOOZE feeding the piezo tone generator.
// Define ALARM_CTRL_WEEKDAY_EN to add day-of-week masking of the match.
module alarm_ctrl_unit
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int SNOOZE_S       = SNOOZE_S_DEF,
  parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic         CLK,
  input logic         RESET,
  alarm_ctrl_unit_if.slave bus
);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_S - 1);
  localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

  logic             trigger;
  tod_t             cur;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       left, left_nxt;
  logic             en_q, doing_q;

  assign cur = '{hour: bus.CUR_HOUR, min: bus.CUR_MIN, sec: bus.CUR_SEC};

  alarm_match u_match (
    .CLK          (CLK),
    .RESET        (RESET),
    .SEC_TICK     (bus.SEC_TICK),
    .cur          (cur),
    .ALM_HOUR     (bus.ALM_HOUR),
    .ALM_MIN      (bus.ALM_MIN),
    .ALM_ARMED    (bus.ALM_ARMED),
`ifdef ALARM_CTRL_WEEKDAY_EN
    .CUR_DOW      (bus.CUR_DOW),
    .ALM_DOW_MASK (bus.ALM_DOW_MASK),
`endif
    .TRIGGER      (trigger)
  );

  // Priority: disarm > stop > snooze > timeout/expiry > match.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    left_nxt  = left;
    if (!bus.ALM_ARMED) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state_nxt = ST_RINGING;
            cnt_nxt   = '0;
            left_nxt  = SNZ_MAX;
          end
        end
        ST_RINGING: begin
          if (bus.BTN_STOP) begin
            state_nxt = ST_IDLE;
          end else if (bus.BTN_SNOOZE && left != 2'd0) begin
            state_nxt = ST_SNOOZE;
            cnt_nxt   = SNZ_LOAD;
            left_nxt  = left - 2'd1;
          end else if (bus.SEC_TICK) begin
            if (cnt == RING_LAST) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt   = cnt + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (bus.BTN_STOP) begin
            state_nxt = ST_IDLE;
          end else if (bus.SEC_TICK) begin
            if (cnt == '0) state_nxt = ST_RINGING;
            else           cnt_nxt   = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      left    <= SNZ_MAX;
      en_q    <= 1'b0;
      doing_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      left    <= left_nxt;
      en_q    <= bus.ALM_ARMED;
      doing_q <= (state_nxt == ST_RINGING);
    end
  end

  assign bus.ALM_STATE    = state;
  assign bus.SNOOZE_LEFT  = left;
  assign bus.ALARM_ENABLE = en_q;
  assign bus.ALARM_DOING  = doing_q;
endmodule

// File: tb/tb_alarm_ctrl_unit.sv
// Directed test-plan scenarios followed by randomized traffic, all scored
// against a seconds-of-day / elapsed-seconds reference model.
module tb_alarm_ctrl_unit;
  import alarm_pkg::*;

  localparam int RT = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  alarm_ctrl_unit_if bus ();

  alarm_ctrl_unit #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SS), .MAX_SNOOZE(MS), .CNT_W(9)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus state
  int tod = 0;           // seconds since midnight
  int ah = 7, am = 30;
  bit armed = 1'b0;
  int dow = 0;
  bit [6:0] mask = 7'h7f;

  // reference model
  int m_mode = 0;        // 0 idle, 1 ringing, 2 snoozing
  int m_ring = 0;        // ticks seen in the current ring episode
  int m_snz  = 0;        // ticks seen in the current snooze
  int m_left = MS;
  bit m_fired = 1'b0;
  bit e_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hh(); return tod / 3600; endfunction
  function automatic int mm(); return (tod / 60) % 60; endfunction
  function automatic int ss(); return tod % 60; endfunction

  task automatic model(input bit rst, input bit tick, input bit stop, input bit snz);
    bit trig;
    bit day_ok;
    bit in_min;
    day_ok = 1'b1;
`ifdef ALARM_CTRL_WEEKDAY_EN
    day_ok = (dow < 7) && mask[dow];
`endif
    in_min = (hh() == ah) && (mm() == am);
    trig = tick && armed && in_min && (ss() == 0) && !m_fired && day_ok;
    if (rst) begin
      m_mode = 0; m_ring = 0; m_snz = 0; m_left = MS; m_fired = 1'b0; e_en = 1'b0;
    end else begin
      e_en = armed;
      if (!in_min) m_fired = 1'b0;
      else if (trig) m_fired = 1'b1;
      if (!armed) m_mode = 0;
      else if (m_mode == 0) begin
        if (trig) begin m_mode = 1; m_ring = 0; m_left = MS; end
      end else if (m_mode == 1) begin
        if (stop) m_mode = 0;
        else if (snz && m_left > 0) begin m_mode = 2; m_left--; m_snz = 0; end
        else if (tick) begin
          m_ring++;
          if (m_ring == RT) m_mode = 0;
        end
      end else begin
        if (stop) m_mode = 0;
        else if (tick) begin
          m_snz++;
          if (m_snz == SS) begin m_mode = 1; m_ring = 0; end
        end
      end
    end
  endtask

  // One clock: present inputs, clock, update model, compare all outputs.
  task automatic cyc(input bit rst, input bit tick, input bit stop, input bit snz);
    RESET          = rst;
    bus.SEC_TICK   = tick;
    bus.BTN_STOP   = stop;
    bus.BTN_SNOOZE = snz;
    bus.ALM_ARMED  = armed;
    bus.ALM_HOUR   = 5'(ah);
    bus.ALM_MIN    = 6'(am);
    bus.CUR_HOUR   = 5'(hh());
    bus.CUR_MIN    = 6'(mm());
    bus.CUR_SEC    = 6'(ss());
`ifdef ALARM_CTRL_WEEKDAY_EN
    bus.CUR_DOW      = 3'(dow);
    bus.ALM_DOW_MASK = mask;
`endif
    @(posedge CLK);
    model(rst, tick, stop, snz);
    #1;
    chk("enable", 32'(bus.ALARM_ENABLE), 32'(e_en));
    chk("doing",  32'(bus.ALARM_DOING),  32'(m_mode == 1));
    chk("state",  32'(bus.ALM_STATE),    32'(m_mode));
    chk("left",   32'(bus.SNOOZE_LEFT),  32'(m_left));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tod = (tod + 1) % 86400;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Park one second before the alarm minute, then tick into it.
  task automatic ring_up();
    tod = ah * 3600 + am * 60 - 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(1);
  endtask

  initial begin
    armed = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_state", 32'(bus.ALM_STATE), 32'd0);
    chk("rst_left",  32'(bus.SNOOZE_LEFT), 32'd3);
    chk("rst_en",    32'(bus.ALARM_ENABLE), 32'd0);

    // 07:29:59 -> 07:30:00 rings; ringing runs out on the 60th tick
    armed = 1'b1; ah = 7; am = 30;
    tod = 7 * 3600 + 29 * 60 + 58;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick_n(1);
    chk("pre_match", 32'(bus.ALARM_DOING), 32'd0);
    tick_n(1);
    chk("match_doing", 32'(bus.ALARM_DOING), 32'd1);
    tick_n(59);
    chk("ring_59", 32'(bus.ALM_STATE), 32'd1);
    tick_n(1);
    chk("timeout_state", 32'(bus.ALM_STATE), 32'd0);
    chk("timeout_doing", 32'(bus.ALARM_DOING), 32'd0);

    // a second 07:30:00 tick within the same matching minute must not re-fire
    ring_up();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("no_refire", 32'(bus.ALM_STATE), 32'd0);

    // snooze cycles, then the exhausted snooze button is ignored
    ring_up();
    for (int k = 0; k < MS; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("snz_state", 32'(bus.ALM_STATE), 32'd2);
      chk("snz_left",  32'(bus.SNOOZE_LEFT), 32'(MS - 1 - k));
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      tick_n(SS - 1);
      chk("snz_hold", 32'(bus.ALM_STATE), 32'd2);
      tick_n(1);
      chk("snz_expire", 32'(bus.ALM_STATE), 32'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("snz4_ignored", 32'(bus.ALM_STATE), 32'd1);
    chk("snz4_left",    32'(bus.SNOOZE_LEFT), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // stop wins over snooze
    tick_n(70);
    ring_up();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("stop_snz_state", 32'(bus.ALM_STATE), 32'd0);
    chk("stop_snz_left",  32'(bus.SNOOZE_LEFT), 32'd3);

    // disarm while snoozing
    tick_n(70);
    ring_up();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    armed = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("disarm_state", 32'(bus.ALM_STATE), 32'd0);
    chk("disarm_en",    32'(bus.ALARM_ENABLE), 32'd0);
    armed = 1'b1;

    // reset mid-ring
    tick_n(70);
    ring_up();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_doing", 32'(bus.ALARM_DOING), 32'd0);
    chk("rst_mid_en",    32'(bus.ALARM_ENABLE), 32'd0);

`ifdef ALARM_CTRL_WEEKDAY_EN
    mask = 7'b0111110;
    dow = 0;
    tick_n(70);
    ring_up();
    chk("dow_sun", 32'(bus.ALM_STATE), 32'd0);
    dow = 1;
    tick_n(70);
    ring_up();
    chk("dow_mon", 32'(bus.ALM_STATE), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    dow = 7;
    mask = 7'h7f;
    tick_n(70);
    ring_up();
    chk("dow_7", 32'(bus.ALM_STATE), 32'd0);
    dow = 1;
`endif

    // randomized traffic around the alarm minute
    ah = int'($urandom_range(0, 23));
    am = int'($urandom_range(1, 59));
    for (int i = 0; i < 20000; i++) begin
      bit rst, tk, st, sz;
      if ($urandom_range(0, 299) == 0)
        tod = (ah * 3600 + am * 60 - int'($urandom_range(1, 6)) + 86400) % 86400;
      if ($urandom_range(0, 511) == 0) armed = ~armed;
`ifdef ALARM_CTRL_WEEKDAY_EN
      if ($urandom_range(0, 299) == 0) begin
        dow  = int'($urandom_range(0, 7));
        mask = 7'($urandom);
      end
`endif
      rst = ($urandom_range(0, 1999) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 63) == 0);
      sz  = ($urandom_range(0, 15) == 0);
      if (tk) tod = (tod + 1) % 86400;
      cyc(rst, tk, st, sz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
